pll_rst_ctrl: RTL and testbench
===============================

Name: pll_rst_ctrl

Overview:
PLL reset/lock supervisor running on the 100 MHz board reference clock. It is the initiating end of the PLL RST/LOCKED interface of the core clock generator.
- Drives the PLL RST input and watches LOCKED.
- Retries lock on timeout and declares failure after a bounded number of attempts.
- Issues a clean ready indication that gates reset release for the rest of the SoC.

Parameters:
RST_PULSE_CYCLES, 16, cycles o_pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 100000, cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 100 MHz)
STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before ready
MAX_RETRIES, 3, failed attempts tolerated before FAIL
RW, $clog2(MAX_RETRIES+1), width of o_retry_cnt (derived, not overridden)

Ports:
i_clk  in  1  reference clock (100 MHz)
i_rst  in  1  synchronous, active-high reset
i_locked  in  1  PLL LOCKED, asynchronous to i_clk
o_pll_rst  out  1  PLL RST request, registered
o_ready  out  1  lock confirmed stable, registered
o_fail  out  1  retries exhausted, sticky until i_rst
o_retry_cnt  out  RW  failed attempts in current acquisition
o_lock_lost  out  1  one-cycle pulse on lock loss while ready

Behaviour:
- Reset (i_rst high at a clock edge), one cycle later:
  - state=RESET, cnt=0, retry=0, sync flops=0.
  - o_pll_rst=1, o_ready=0, o_fail=0, o_retry_cnt=0, o_lock_lost=0.
  - i_rst asserted mid-operation aborts any state identically.
- i_locked passes through a 2-flop synchronizer to give locked_s; input-to-locked_s latency is 2 cycles.
- Single counter cnt, width = $clog2 of the largest of the three cycle parameters. cnt clears on every state change and never wraps.
- State machine:
  - RESET: cnt++. At cnt==RST_PULSE_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK:
    - locked_s=1: go to STABLE.
    - Otherwise, at cnt==LOCK_TIMEOUT_CYCLES-1: if retry==MAX_RETRIES go to FAIL; else retry++ and go to RESET.
    - If locked_s rises on the timeout cycle, lock wins.
  - STABLE:
    - locked_s=0: go to WAIT_LOCK, cnt restarts, retry unchanged. This is lock chatter, not a failed attempt.
    - At cnt==STABLE_CYCLES-1 with locked_s=1: go to RUN and set retry=0.
  - RUN: on a loss event, go to RESET and pulse o_lock_lost for exactly one cycle, registered with the transition. retry stays 0.
  - FAIL: terminal. Holds o_pll_rst=1 and o_fail=1. Leaves only via i_rst.
- Outputs are registered decodes of the next state:
  - o_pll_rst=1 in RESET and FAIL.
  - o_ready=1 only in RUN.
  - o_retry_cnt=retry.
  - The cycle the FSM enters a state, its outputs are valid.
- o_pll_rst high time per attempt is exactly RST_PULSE_CYCLES cycles after i_rst deasserts or after the retry decision.
- Loss event: locked_s==0 for one cycle in RUN (see Optional Feature).

Optional Feature:
- Macro PLL_RST_CTRL_GLITCH_FILTER_EN.
- Defined: a loss event in RUN requires locked_s==0 for 4 consecutive cycles, tracked by a 2-bit filter counter that clears on any locked_s==1 and on leaving RUN. Loss latency is 2+4 cycles from i_locked falling.
- Undefined: the filter counter is absent and a single low locked_s cycle is a loss event.
- STABLE and WAIT_LOCK behaviour is identical in both builds.

Decomposition:
- Package pll_rst_pkg: state enum (RESET, WAIT_LOCK, STABLE, RUN, FAIL), filter depth constant LOSS_FILTER_CYCLES=4, and the counter-width helper function.
- Sub-module sync_2ff (1-bit, reset to 0 on i_rst) for the i_locked synchronizer, reused later for other async status inputs.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Nominal lock: release i_rst, raise i_locked 10 cycles later. Required: o_pll_rst high exactly 4 cycles; o_ready rises 2+8 cycles (+1 registration) after i_locked rises; o_retry_cnt=0.
2. Retry then lock: i_locked low for two full timeouts, then high. Required: three o_pll_rst pulses of 4 cycles each; o_retry_cnt steps 0→1→2, then returns to 0 when o_ready=1; o_fail=0.
3. Exhaustion: i_locked held low. Required: after the 3rd timeout o_fail=1 and o_pll_rst=1 permanently, o_retry_cnt=2. A later i_locked=1 has no effect until i_rst.
4. Chatter in STABLE: i_locked high 5 cycles, low 3, then high. Required: no o_pll_rst pulse; o_ready only after 8 further stable cycles; retry unchanged.
5. Lock loss in RUN: drop i_locked for 1 cycle.
   - Filter undefined: exactly one o_lock_lost pulse, o_ready falls, 4-cycle o_pll_rst.
   - Filter defined: no effect from the 1-cycle drop; a 5-cycle drop produces the pulse.
6. Mid-operation reset: assert i_rst during WAIT_LOCK with retry=1. Required: next cycle all outputs at reset values, o_retry_cnt=0, o_pll_rst=1.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared types and helpers for the PLL reset/lock supervisor.
// Holds the supervisor state encoding, the loss-filter depth and the counter-width helper.
package pll_rst_pkg;

   typedef enum logic [2:0] {
      RESET     = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } pll_state_e;

   localparam int unsigned LOSS_FILTER_CYCLES = 4;

   // Width of a counter able to reach (largest cycle parameter - 1), minimum one bit.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit; both stages clear on i_rst.
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset/lock supervisor: pulses PLL RST, waits for a stable LOCKED, retries on timeout.
// Build option PLL_RST_CTRL_GLITCH_FILTER_EN: lock loss in RUN needs LOSS_FILTER_CYCLES consecutive lows.
module pll_rst_ctrl
   import pll_rst_pkg::*;
#(
   parameter  int unsigned RST_PULSE_CYCLES    = 16,
   parameter  int unsigned LOCK_TIMEOUT_CYCLES = 100000,
   parameter  int unsigned STABLE_CYCLES       = 1024,
   parameter  int unsigned MAX_RETRIES         = 3,
   localparam int unsigned RW                  = $clog2(MAX_RETRIES + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_locked,
   output logic          o_pll_rst,
   output logic          o_ready,
   output logic          o_fail,
   output logic [RW-1:0] o_retry_cnt,
   output logic          o_lock_lost
);

   localparam int unsigned CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);

   pll_state_e    r_state;
   pll_state_e    w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [RW-1:0] r_retry;
   logic [RW-1:0] w_retry_nxt;

   logic w_locked_s;
   logic w_loss;
   logic w_rst_done;
   logic w_timeout;
   logic w_stable_done;
   logic w_retry_max;

   logic w_pll_rst_nxt;
   logic w_ready_nxt;
   logic w_fail_nxt;
   logic w_lock_lost_nxt;

   sync_2ff u_locked_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_locked),
      .o_q   (w_locked_s)
   );

   assign w_rst_done    = (r_cnt == CW'(RST_PULSE_CYCLES - 1));
   assign w_timeout     = (r_cnt == CW'(LOCK_TIMEOUT_CYCLES - 1));
   assign w_stable_done = (r_cnt == CW'(STABLE_CYCLES - 1));
   assign w_retry_max   = (r_retry == RW'(MAX_RETRIES));

`ifdef PLL_RST_CTRL_GLITCH_FILTER_EN
   localparam int unsigned FW = $clog2(LOSS_FILTER_CYCLES);

   logic [FW-1:0] r_flt;

   // Counts consecutive low synchronized-lock cycles while in RUN.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_flt <= '0;
      end else if ((r_state != RUN) || w_locked_s || (w_state_nxt != RUN)) begin
         r_flt <= '0;
      end else begin
         r_flt <= r_flt + FW'(1);
      end
   end

   assign w_loss = (r_state == RUN) && !w_locked_s && (r_flt == FW'(LOSS_FILTER_CYCLES - 1));
`else
   assign w_loss = (r_state == RUN) && !w_locked_s;
`endif

   // State, counter, retry and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= RESET;
         r_cnt       <= '0;
         r_retry     <= '0;
         o_pll_rst   <= 1'b1;
         o_ready     <= 1'b0;
         o_fail      <= 1'b0;
         o_retry_cnt <= '0;
         o_lock_lost <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_retry     <= w_retry_nxt;
         o_pll_rst   <= w_pll_rst_nxt;
         o_ready     <= w_ready_nxt;
         o_fail      <= w_fail_nxt;
         o_retry_cnt <= w_retry_nxt;
         o_lock_lost <= w_lock_lost_nxt;
      end
   end

   // Next-state and retry bookkeeping; lock wins over a coincident timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_retry_nxt = r_retry;
      case (r_state)
         RESET: begin
            if (w_rst_done) w_state_nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (w_locked_s) begin
               w_state_nxt = STABLE;
            end else if (w_timeout) begin
               if (w_retry_max) begin
                  w_state_nxt = FAIL;
               end else begin
                  w_retry_nxt = r_retry + RW'(1);
                  w_state_nxt = RESET;
               end
            end
         end
         STABLE: begin
            if (!w_locked_s) begin
               w_state_nxt = WAIT_LOCK;
            end else if (w_stable_done) begin
               w_state_nxt = RUN;
               w_retry_nxt = '0;
            end
         end
         RUN: begin
            if (w_loss) w_state_nxt = RESET;
         end
         FAIL: begin
            w_state_nxt = FAIL;
         end
         default: begin
            w_state_nxt = RESET;
            w_retry_nxt = '0;
         end
      endcase
   end

   // Output decode of the next state; counter restarts on any state change and saturates.
   always_comb begin
      w_cnt_nxt       = '0;
      w_pll_rst_nxt   = 1'b0;
      w_ready_nxt     = 1'b0;
      w_fail_nxt      = 1'b0;
      w_lock_lost_nxt = 1'b0;
      if (w_state_nxt == r_state) begin
         w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
      end
      w_pll_rst_nxt   = (w_state_nxt == RESET) || (w_state_nxt == FAIL);
      w_ready_nxt     = (w_state_nxt == RUN);
      w_fail_nxt      = (w_state_nxt == FAIL);
      w_lock_lost_nxt = (r_state == RUN) && (w_state_nxt == RESET);
   end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Directed self-checking bench for pll_rst_ctrl with small timing parameters.
module tb_pll_rst_ctrl;

   logic       i_clk;
   logic       i_rst;
   logic       i_locked;
   logic       o_pll_rst;
   logic       o_ready;
   logic       o_fail;
   logic [1:0] o_retry_cnt;
   logic       o_lock_lost;

   int checks;
   int errors;

   pll_rst_ctrl #(
      .RST_PULSE_CYCLES    (4),
      .LOCK_TIMEOUT_CYCLES (20),
      .STABLE_CYCLES       (8),
      .MAX_RETRIES         (2)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_locked    (i_locked),
      .o_pll_rst   (o_pll_rst),
      .o_ready     (o_ready),
      .o_fail      (o_fail),
      .o_retry_cnt (o_retry_cnt),
      .o_lock_lost (o_lock_lost)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   // Leaves the bench at the sample point of the last reset edge, with i_rst released.
   task automatic apply_reset(input logic lk);
      i_locked = lk;
      i_rst    = 1'b1;
      cyc(2);
      i_rst    = 1'b0;
   endtask

   task automatic count_high(output int hi);
      hi = 0;
      while (o_pll_rst && hi < 50) begin
         hi++;
         cyc(1);
      end
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!o_ready && n < 100) begin
         n++;
         cyc(1);
      end
   endtask

   task automatic test_reset;
      i_locked = 1'b1;
      i_rst    = 1'b1;
      cyc(3);
      checks++; if (o_pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst got %b exp 1", o_pll_rst); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", o_ready); end
      checks++; if (o_fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b exp 0", o_fail); end
      checks++; if (o_retry_cnt !== 2'd0) begin errors++; $display("FAIL reset_retry got %0d exp 0", o_retry_cnt); end
      checks++; if (o_lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost got %b exp 0", o_lock_lost); end
      i_rst = 1'b0;
   endtask

   task automatic test_nominal;
      int hi, n;
      apply_reset(1'b0);
      count_high(hi);
      checks++; if (hi != 4) begin errors++; $display("FAIL nominal_pulse_len got %0d exp 4", hi); end
      cyc(6);
      i_locked = 1'b1;
      wait_ready(n);
      checks++; if (n != 11) begin errors++; $display("FAIL nominal_ready_latency got %0d exp 11", n); end
      checks++; if (o_retry_cnt !== 2'd0) begin errors++; $display("FAIL nominal_retry got %0d exp 0", o_retry_cnt); end
      checks++; if (o_pll_rst !== 1'b0) begin errors++; $display("FAIL nominal_pll_rst got %b exp 0", o_pll_rst); end
   endtask

   task automatic test_retry;
      int hi, lo, n;
      apply_reset(1'b0);
      for (int p = 0; p < 3; p++) begin
         checks++; if (o_retry_cnt !== 2'(p)) begin errors++; $display("FAIL retry_cnt_pulse%0d got %0d exp %0d", p, o_retry_cnt, p); end
         count_high(hi);
         checks++; if (hi != 4) begin errors++; $display("FAIL retry_pulse%0d_len got %0d exp 4", p, hi); end
         if (p < 2) begin
            lo = 0;
            while (!o_pll_rst && lo < 100) begin
               lo++;
               cyc(1);
            end
            checks++; if (lo != 20) begin errors++; $display("FAIL retry_wait%0d_len got %0d exp 20", p, lo); end
         end
      end
      i_locked = 1'b1;
      wait_ready(n);
      checks++; if (n != 11) begin errors++; $display("FAIL retry_ready_latency got %0d exp 11", n); end
      checks++; if (o_retry_cnt !== 2'd0) begin errors++; $display("FAIL retry_cnt_cleared got %0d exp 0", o_retry_cnt); end
      checks++; if (o_fail !== 1'b0) begin errors++; $display("FAIL retry_fail got %b exp 0", o_fail); end
   endtask

   task automatic test_exhaust;
      apply_reset(1'b0);
      cyc(71);
      checks++; if (o_fail !== 1'b0) begin errors++; $display("FAIL exhaust_fail_early got %b exp 0", o_fail); end
      cyc(1);
      checks++; if (o_fail !== 1'b1) begin errors++; $display("FAIL exhaust_fail got %b exp 1", o_fail); end
      checks++; if (o_pll_rst !== 1'b1) begin errors++; $display("FAIL exhaust_pll_rst got %b exp 1", o_pll_rst); end
      checks++; if (o_retry_cnt !== 2'd2) begin errors++; $display("FAIL exhaust_retry got %0d exp 2", o_retry_cnt); end
      i_locked = 1'b1;
      cyc(30);
      checks++; if (o_fail !== 1'b1) begin errors++; $display("FAIL exhaust_sticky_fail got %b exp 1", o_fail); end
      checks++; if (o_pll_rst !== 1'b1) begin errors++; $display("FAIL exhaust_sticky_pll_rst got %b exp 1", o_pll_rst); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL exhaust_ready got %b exp 0", o_ready); end
      apply_reset(1'b0);
      checks++; if (o_fail !== 1'b0) begin errors++; $display("FAIL exhaust_fail_cleared got %b exp 0", o_fail); end
   endtask

   task automatic test_timeout_boundary;
      apply_reset(1'b0);
      cyc(21);
      i_locked = 1'b1;
      cyc(3);
      checks++; if (o_pll_rst !== 1'b0) begin errors++; $display("FAIL boundary_lock_wins_pll_rst got %b exp 0", o_pll_rst); end
      checks++; if (o_retry_cnt !== 2'd0) begin errors++; $display("FAIL boundary_lock_wins_retry got %0d exp 0", o_retry_cnt); end
      cyc(8);
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL boundary_lock_wins_ready got %b exp 1", o_ready); end
      apply_reset(1'b0);
      cyc(22);
      i_locked = 1'b1;
      cyc(2);
      checks++; if (o_pll_rst !== 1'b1) begin errors++; $display("FAIL boundary_late_lock_pll_rst got %b exp 1", o_pll_rst); end
      checks++; if (o_retry_cnt !== 2'd1) begin errors++; $display("FAIL boundary_late_lock_retry got %0d exp 1", o_retry_cnt); end
   endtask

   task automatic test_chatter;
      int n;
      logic saw;
      apply_reset(1'b0);
      cyc(4);
      checks++; if (o_pll_rst !== 1'b0) begin errors++; $display("FAIL chatter_wait_pll_rst got %b exp 0", o_pll_rst); end
      saw = 1'b0;
      i_locked = 1'b1;
      for (int k = 0; k < 5; k++) begin cyc(1); saw |= o_pll_rst; end
      i_locked = 1'b0;
      for (int k = 0; k < 3; k++) begin cyc(1); saw |= o_pll_rst; end
      i_locked = 1'b1;
      n = 0;
      while (!o_ready && n < 100) begin
         n++;
         cyc(1);
         saw |= o_pll_rst;
      end
      checks++; if (n != 11) begin errors++; $display("FAIL chatter_ready_latency got %0d exp 11", n); end
      checks++; if (saw !== 1'b0) begin errors++; $display("FAIL chatter_pll_rst_pulse got %b exp 0", saw); end
      checks++; if (o_retry_cnt !== 2'd0) begin errors++; $display("FAIL chatter_retry got %0d exp 0", o_retry_cnt); end
   endtask

   task automatic loss_window(input int drop, input int len, output int ll_cnt,
                              output int ll_first, output int hi_cnt, output int rdy_low);
      ll_cnt = 0; ll_first = -1; hi_cnt = 0; rdy_low = 0;
      i_locked = 1'b0;
      for (int k = 1; k <= len; k++) begin
         cyc(1);
         if (o_lock_lost) begin
            ll_cnt++;
            if (ll_first < 0) ll_first = k;
         end
         if (o_pll_rst) hi_cnt++;
         if (!o_ready) rdy_low++;
         if (k == drop) i_locked = 1'b1;
      end
   endtask

   task automatic test_lock_loss;
      int n, ll_cnt, ll_first, hi_cnt, rdy_low;
      apply_reset(1'b1);
      wait_ready(n);
      checks++; if (n != 13) begin errors++; $display("FAIL loss_initial_ready got %0d exp 13", n); end
      cyc(2);
`ifdef PLL_RST_CTRL_GLITCH_FILTER_EN
      loss_window(1, 12, ll_cnt, ll_first, hi_cnt, rdy_low);
      checks++; if (ll_cnt != 0) begin errors++; $display("FAIL loss_glitch_pulses got %0d exp 0", ll_cnt); end
      checks++; if (hi_cnt != 0) begin errors++; $display("FAIL loss_glitch_pll_rst got %0d exp 0", hi_cnt); end
      checks++; if (rdy_low != 0) begin errors++; $display("FAIL loss_glitch_ready_low got %0d exp 0", rdy_low); end
      loss_window(5, 24, ll_cnt, ll_first, hi_cnt, rdy_low);
      checks++; if (ll_cnt != 1) begin errors++; $display("FAIL loss_pulses got %0d exp 1", ll_cnt); end
      checks++; if (ll_first != 6) begin errors++; $display("FAIL loss_latency got %0d exp 6", ll_first); end
      checks++; if (hi_cnt != 4) begin errors++; $display("FAIL loss_pll_rst_len got %0d exp 4", hi_cnt); end
      checks++; if (rdy_low != 13) begin errors++; $display("FAIL loss_ready_low got %0d exp 13", rdy_low); end
`else
      loss_window(1, 20, ll_cnt, ll_first, hi_cnt, rdy_low);
      checks++; if (ll_cnt != 1) begin errors++; $display("FAIL loss_pulses got %0d exp 1", ll_cnt); end
      checks++; if (ll_first != 3) begin errors++; $display("FAIL loss_latency got %0d exp 3", ll_first); end
      checks++; if (hi_cnt != 4) begin errors++; $display("FAIL loss_pll_rst_len got %0d exp 4", hi_cnt); end
      checks++; if (rdy_low != 13) begin errors++; $display("FAIL loss_ready_low got %0d exp 13", rdy_low); end
`endif
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL loss_relock_ready got %b exp 1", o_ready); end
      checks++; if (o_retry_cnt !== 2'd0) begin errors++; $display("FAIL loss_retry got %0d exp 0", o_retry_cnt); end
   endtask

   task automatic test_midreset;
      int hi;
      apply_reset(1'b0);
      cyc(33);
      checks++; if (o_retry_cnt !== 2'd1) begin errors++; $display("FAIL mid_pre_retry got %0d exp 1", o_retry_cnt); end
      checks++; if (o_pll_rst !== 1'b0) begin errors++; $display("FAIL mid_pre_pll_rst got %b exp 0", o_pll_rst); end
      i_rst = 1'b1;
      cyc(1);
      checks++; if (o_pll_rst !== 1'b1) begin errors++; $display("FAIL mid_pll_rst got %b exp 1", o_pll_rst); end
      checks++; if (o_retry_cnt !== 2'd0) begin errors++; $display("FAIL mid_retry got %0d exp 0", o_retry_cnt); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b exp 0", o_ready); end
      checks++; if (o_fail !== 1'b0) begin errors++; $display("FAIL mid_fail got %b exp 0", o_fail); end
      checks++; if (o_lock_lost !== 1'b0) begin errors++; $display("FAIL mid_lock_lost got %b exp 0", o_lock_lost); end
      i_rst = 1'b0;
      count_high(hi);
      checks++; if (hi != 4) begin errors++; $display("FAIL mid_pulse_len got %0d exp 4", hi); end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      i_rst    = 1'b1;
      i_locked = 1'b0;
      test_reset();
      test_nominal();
      test_retry();
      test_exhaust();
      test_timeout_boundary();
      test_chatter();
      test_lock_loss();
      test_midreset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
